// File: rtl/em_telem_serializer.sv
// Telemetry serializer for the error-monitor latch bank: snapshots EMN on a read request,
// shifts out sync + error bits + odd parity, then optionally pulses a per-bit clear.
module em_telem_serializer #(
    parameter int unsigned       NUM_EM     = 26,
    parameter int unsigned       SYNC_W     = 3,
    parameter logic [SYNC_W-1:0] SYNC_PAT   = 3'b101,
    parameter bit                CLR_AFTER  = 1'b1,
    parameter int unsigned       CLR_CYCLES = 4
) (
    input  logic              SIM_CLK,
    input  logic              SIM_RST,
    input  logic              V1,
    input  logic [NUM_EM-1:0] EMN,
    input  logic              RD_REQ,
    input  logic              SHIFT_EN,
    output logic              TLM_DATA,
    output logic              TLM_GATE,
    output logic              RD_BUSY,
    output logic              RD_OVR,
    output logic              FRAME_DONE,
    output logic              EM_CLR,
    output logic [NUM_EM-1:0] EM_CLR_MASK,
    output logic              ANY_ERR
);

    localparam int unsigned MAX_FIELD = (NUM_EM > SYNC_W) ? NUM_EM : SYNC_W;
    localparam int unsigned CNT_W     = $clog2(MAX_FIELD) + 1;
    localparam int unsigned CLR_W     = $clog2(CLR_CYCLES) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_PAR,
        S_CLR
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CLR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [NUM_EM-1:0]  snap_q, snap_d;
    logic [NUM_EM-1:0]  data_sr_q, data_sr_d;
    logic [SYNC_W-1:0]  sync_sr_q, sync_sr_d;
    logic               tlm_data_q, tlm_data_d;
    logic               tlm_gate_q, tlm_gate_d;
    logic               rd_busy_q, rd_busy_d;
    logic               rd_ovr_q, rd_ovr_d;
    logic               frame_done_q, frame_done_d;
    logic               em_clr_q, em_clr_d;
    logic [NUM_EM-1:0]  mask_q, mask_d;

    // State and output registers
    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            clr_cnt_q    <= '0;
            snap_q       <= '0;
            data_sr_q    <= '0;
            sync_sr_q    <= '0;
            tlm_data_q   <= 1'b0;
            tlm_gate_q   <= 1'b0;
            rd_busy_q    <= 1'b0;
            rd_ovr_q     <= 1'b0;
            frame_done_q <= 1'b0;
            em_clr_q     <= 1'b0;
            mask_q       <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            clr_cnt_q    <= clr_cnt_d;
            snap_q       <= snap_d;
            data_sr_q    <= data_sr_d;
            sync_sr_q    <= sync_sr_d;
            tlm_data_q   <= tlm_data_d;
            tlm_gate_q   <= tlm_gate_d;
            rd_busy_q    <= rd_busy_d;
            rd_ovr_q     <= rd_ovr_d;
            frame_done_q <= frame_done_d;
            em_clr_q     <= em_clr_d;
            mask_q       <= mask_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        clr_cnt_d    = clr_cnt_q;
        snap_d       = snap_q;
        data_sr_d    = data_sr_q;
        sync_sr_d    = sync_sr_q;
        tlm_data_d   = tlm_data_q;
        tlm_gate_d   = tlm_gate_q;
        rd_ovr_d     = rd_ovr_q;
        frame_done_d = 1'b0;
        em_clr_d     = em_clr_q;
        mask_d       = mask_q;

        if (!V1) begin
            // Supply loss aborts everything except the sticky overrun flag
            state_d    = S_IDLE;
            bit_cnt_d  = '0;
            clr_cnt_d  = '0;
            tlm_data_d = 1'b0;
            tlm_gate_d = 1'b0;
            em_clr_d   = 1'b0;
            mask_d     = '0;
        end else begin
            // The FRAME_DONE cycle still counts as busy for incoming requests
            if (RD_REQ && ((state_q != S_IDLE) || frame_done_q)) begin
                rd_ovr_d = 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (RD_REQ && !frame_done_q) begin
                        snap_d     = ~EMN;
                        data_sr_d  = ~EMN;
                        sync_sr_d  = SYNC_PAT;
                        rd_ovr_d   = 1'b0;
                        bit_cnt_d  = '0;
                        tlm_gate_d = 1'b1;
                        tlm_data_d = SYNC_PAT[SYNC_W-1];
                        state_d    = S_SYNC;
                    end
                end
                S_SYNC: begin
                    if (SHIFT_EN) begin
                        if (bit_cnt_q == CNT_W'(SYNC_W - 1)) begin
                            state_d    = S_DATA;
                            bit_cnt_d  = '0;
                            tlm_data_d = data_sr_q[0];
                        end else begin
                            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                            sync_sr_d  = sync_sr_q << 1;
                            tlm_data_d = sync_sr_d[SYNC_W-1];
                        end
                    end
                end
                S_DATA: begin
                    if (SHIFT_EN) begin
                        if (bit_cnt_q == CNT_W'(NUM_EM - 1)) begin
                            state_d    = S_PAR;
                            bit_cnt_d  = '0;
                            tlm_data_d = ~^snap_q;
                        end else begin
                            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                            data_sr_d  = data_sr_q >> 1;
                            tlm_data_d = data_sr_d[0];
                        end
                    end
                end
                S_PAR: begin
                    if (SHIFT_EN) begin
                        tlm_gate_d   = 1'b0;
                        tlm_data_d   = 1'b0;
                        frame_done_d = 1'b1;
                        if (CLR_AFTER && (snap_q != '0)) begin
                            state_d   = S_CLR;
                            clr_cnt_d = '0;
                            em_clr_d  = 1'b1;
                            mask_d    = snap_q;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_CLR: begin
                    if (clr_cnt_q == CLR_W'(CLR_CYCLES - 1)) begin
                        state_d   = S_IDLE;
                        clr_cnt_d = '0;
                        em_clr_d  = 1'b0;
                        mask_d    = '0;
                    end else begin
                        clr_cnt_d = clr_cnt_q + CLR_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        rd_busy_d = (state_d != S_IDLE) || frame_done_d;
    end

    assign TLM_DATA    = tlm_data_q;
    assign TLM_GATE    = tlm_gate_q;
    assign RD_BUSY     = rd_busy_q;
    assign RD_OVR      = rd_ovr_q;
    assign FRAME_DONE  = frame_done_q;
    assign EM_CLR      = em_clr_q;
    assign EM_CLR_MASK = mask_q;
    assign ANY_ERR     = V1 & (|(~EMN));

endmodule
